// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial transmit arbiter: FSM state encoding
// and 8N1 framing constants.
package serial_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;
    localparam int   FRAME_DATA_BITS = 8;

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Byte-source handshake bundle: two level requests with their data buses,
// the transmit enable, and the one-cycle capture acks.
interface serial_tx_arbiter_if;
    logic       transmit_enable;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;

    modport master (
        output transmit_enable, req0, data0, req1, data1,
        input  ack0, ack1
    );

    modport slave (
        input  transmit_enable, req0, data0, req1, data1,
        output ack0, ack1
    );
endinterface

// File: rtl/serial_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational winner, registered pointer that
// moves to favour the loser whenever a grant is taken.
module rr_arbiter2
    import serial_tx_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic winner
);

    logic ptr;

    always_comb begin
        winner = (req0 && req1) ? ptr : req1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (grant_en) begin
            ptr <= ~winner;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one 8N1 serial transmit line between the microprocessor (source 0)
// and the receiver loopback (source 1), granting them round-robin.
module serial_tx_arbiter
    import serial_tx_arbiter_pkg::*;
#(
    parameter int BIT_TICKS = 16,
    parameter int DATA_BITS = FRAME_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_tx_arbiter_if.slave   bus,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 character_sent,
    output logic                 last_src
);

    localparam int TW  = $clog2(BIT_TICKS);
    localparam int BCW = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 ack0_r;
    logic                 ack1_r;
    logic                 last_tick;
    logic                 grant_point;
    logic                 do_grant;
    logic                 winner;

    assign last_tick   = (tick_cnt == TW'(BIT_TICKS - 1));
    assign grant_point = (state == IDLE) || (state == STOP && last_tick);
    assign do_grant    = grant_point && bus.transmit_enable && (bus.req0 || bus.req1);
    assign bus.ack0    = ack0_r;
    assign bus.ack1    = ack1_r;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0     (bus.req0),
        .req1     (bus.req1),
        .grant_en (do_grant),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            serial_out     <= STOP_BIT;
            busy           <= 1'b0;
            ack0_r         <= 1'b0;
            ack1_r         <= 1'b0;
            character_sent <= 1'b0;
            last_src       <= 1'b0;
        end else begin
            ack0_r         <= 1'b0;
            ack1_r         <= 1'b0;
            character_sent <= 1'b0;
            if (state != IDLE) begin
                tick_cnt <= last_tick ? '0 : tick_cnt + 1'b1;
            end

            unique case (state)
                IDLE: ;
                START: if (last_tick) begin
                    state      <= DATA;
                    bit_cnt    <= '0;
                    serial_out <= shift_reg[0];
                end
                DATA: if (last_tick) begin
                    shift_reg <= shift_reg >> 1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        state      <= STOP;
                        serial_out <= STOP_BIT;
                    end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        serial_out <= shift_reg[1];
                    end
                end
                STOP: if (last_tick) begin
                    character_sent <= 1'b1;
                    if (!do_grant) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        serial_out <= STOP_BIT;
                    end
                end
            endcase

            // A grant at the end of STOP overrides the fall back to IDLE,
            // so the next start bit follows the stop bit with no gap.
            if (do_grant) begin
                state      <= START;
                tick_cnt   <= '0;
                shift_reg  <= winner ? bus.data1 : bus.data0;
                last_src   <= winner;
                ack0_r     <= ~winner;
                ack1_r     <= winner;
                serial_out <= START_BIT;
                busy       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: stimulus queues expected frames,
// a monitor decodes each acked frame off serial_out and compares.
module tb_serial_tx_arbiter;

    localparam int BT = 4;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_out;
    logic busy;
    logic character_sent;
    logic last_src;

    serial_tx_arbiter_if bus();

    serial_tx_arbiter #(.BIT_TICKS(BT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .serial_out     (serial_out),
        .busy           (busy),
        .character_sent (character_sent),
        .last_src       (last_src)
    );

    always #5 clk = ~clk;

    frame_t exp_q[$];
    int     checks    = 0;
    int     errors    = 0;
    int     char_cnt  = 0;
    int     busy_gap  = 0;
    bit     busy_watch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ack(input bit which, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? bus.ack1 : bus.ack0) && n < budget);
        if (!(which ? bus.ack1 : bus.ack0)) begin
            checks++;
            errors++;
            $display("FAIL wait_ack%0d: no ack within %0d cycles (t=%0t)", which, budget, $time);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still high after %0d cycles (t=%0t)", budget, $time);
        end
    endtask

    always @(negedge clk) begin
        if (character_sent) char_cnt++;
        if (busy_watch && !busy) busy_gap++;
    end

    // Monitor: ack cycle is frame offset 0; each bit spans BT cycles.
    bit         mon_pending = 1'b0;
    bit         mon_aborted;
    frame_t     mon_exp;
    logic [7:0] mon_byte;
    logic       mon_start;
    logic       mon_stop;

    initial begin
        forever begin
            if (!mon_pending) @(negedge clk);
            mon_pending = 1'b0;
            if (rst && (bus.ack0 || bus.ack1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with empty queue", bus.ack0, bus.ack1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("ack_onehot", 32'(bus.ack0 ^ bus.ack1), 1);
                    check("ack_src", 32'(bus.ack1), 32'(mon_exp.src));
                    check("last_src", 32'(last_src), 32'(mon_exp.src));
                    mon_aborted = 1'b0;
                    for (int k = 0; k < 10 * BT; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!rst) begin
                            mon_aborted = 1'b1;
                            break;
                        end
                        if (k == BT / 2) mon_start = serial_out;
                        if (k >= BT + BT / 2 && k < 9 * BT && ((k - BT - BT / 2) % BT) == 0)
                            mon_byte[(k - BT - BT / 2) / BT] = serial_out;
                        if (k == 9 * BT + BT / 2) mon_stop = serial_out;
                    end
                    if (!mon_aborted) begin
                        @(negedge clk);
                        if (rst) begin
                            check("start_bit", 32'(mon_start), 0);
                            check("frame_data", 32'(mon_byte), 32'(mon_exp.data));
                            check("stop_bit", 32'(mon_stop), 1);
                            check("char_sent_at_40", 32'(character_sent), 1);
                            mon_pending = bus.ack0 || bus.ack1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c0;
    int win_ack;
    int win_low;

    initial begin
        bus.transmit_enable = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial_out", 32'(serial_out), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack0", 32'(bus.ack0), 0);
        check("rst_ack1", 32'(bus.ack1), 0);
        check("rst_char_sent", 32'(character_sent), 0);
        check("rst_last_src", 32'(last_src), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single byte A5 from source 0
        bus.data0 = 8'hA5;
        exp_q.push_back('{1'b0, 8'hA5});
        bus.req0 = 1'b1;
        c0 = char_cnt;
        wait_ack(1'b0, 10);
        bus.req0 = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);
        check("single_last_src", 32'(last_src), 0);
        check("single_char_cnt", 32'(char_cnt - c0), 1);

        // Contention out of reset: 11,22,11,22 with no idle gap
        rst = 1'b0;
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        exp_q.push_back('{1'b0, 8'h11});
        exp_q.push_back('{1'b1, 8'h22});
        exp_q.push_back('{1'b0, 8'h11});
        exp_q.push_back('{1'b1, 8'h22});
        @(negedge clk);
        rst = 1'b1;
        busy_gap = 0;
        wait_ack(1'b0, 10);
        busy_watch = 1'b1;
        wait_ack(1'b1, 50);
        wait_ack(1'b0, 50);
        bus.req0 = 1'b0;
        wait_ack(1'b1, 50);
        bus.req1 = 1'b0;
        repeat (10 * BT - 1) @(negedge clk);
        busy_watch = 1'b0;
        check("contention_no_gap", 32'(busy_gap), 0);
        wait_idle(20);
        repeat (2) @(negedge clk);

        // Back-to-back frames from source 1
        bus.data1 = 8'h3C;
        exp_q.push_back('{1'b1, 8'h3C});
        exp_q.push_back('{1'b1, 8'h3C});
        bus.req1 = 1'b1;
        wait_ack(1'b1, 10);
        wait_ack(1'b1, 50);
        check("b2b_char_with_ack", 32'(character_sent), 1);
        check("b2b_start_follows", 32'(serial_out), 0);
        check("b2b_busy", 32'(busy), 1);
        bus.req1 = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);

        // Enable dropped during data bit 3
        bus.data0 = 8'hC3;
        exp_q.push_back('{1'b0, 8'hC3});
        bus.req0 = 1'b1;
        wait_ack(1'b0, 10);
        bus.req0 = 1'b0;
        repeat (4 * BT + 1) @(negedge clk);
        bus.transmit_enable = 1'b0;
        bus.data0 = 8'h5A;
        exp_q.push_back('{1'b0, 8'h5A});
        bus.req0 = 1'b1;
        wait_idle(60);
        win_ack = 0;
        win_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ack0) win_ack++;
            if (!serial_out) win_low++;
        end
        check("gate_no_ack", 32'(win_ack), 0);
        check("gate_line_high", 32'(win_low), 0);
        check("gate_idle", 32'(busy), 0);
        bus.transmit_enable = 1'b1;
        wait_ack(1'b0, 5);
        bus.req0 = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);

        // Reset asserted during data bit 5
        bus.data0 = 8'h0F;
        exp_q.push_back('{1'b0, 8'h0F});
        bus.req0 = 1'b1;
        wait_ack(1'b0, 10);
        bus.req0 = 1'b0;
        repeat (6 * BT + 1) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_serial_out", 32'(serial_out), 1);
        check("midrst_busy", 32'(busy), 0);
        c0 = char_cnt;
        bus.data0 = 8'h77;
        bus.data1 = 8'h88;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        exp_q.push_back('{1'b0, 8'h77});
        exp_q.push_back('{1'b1, 8'h88});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ack(1'b0, 10);
        bus.req0 = 1'b0;
        wait_ack(1'b1, 50);
        bus.req1 = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);
        check("midrst_char_cnt", 32'(char_cnt - c0), 2);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
